adt7420_sched: RTL and testbench

- Sequencer and arbiter in front of the ADT7420 I2C master on the Nexys4-DDR.
- After reset it configures the sensor once, then issues periodic 16-bit temperature reads.
- It shares the single I2C master with a host port that can do single-byte register writes and reads.
- It publishes the latest raw and decoded temperature to the display/UART logic.

---
 rtl/adt7420_sched.sv | 201 ++++++++++++++++++++
 tb/tb_adt7420_sched.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adt7420_sched.sv
// ADT7420 access sequencer: one-time configuration write, periodic 16-bit temperature
// reads, and fixed-priority sharing of the single I2C master with a host register port.
module adt7420_sched #(
   parameter int         SAMPLE_DIV  = 25000000,
   parameter logic [7:0] CFG_ADDR    = 8'h03,
   parameter logic [7:0] CFG_VAL     = 8'h80,
   parameter logic [7:0] TEMP_ADDR   = 8'h00,
   parameter int         TIMEOUT_CYC = 2000000
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        enable,
   input  logic        host_wr_req,
   input  logic [7:0]  host_wr_addr,
   input  logic [7:0]  host_wr_data,
   output logic        host_wr_ack,
   input  logic        host_rd_req,
   input  logic [7:0]  host_rd_addr,
   output logic [7:0]  host_rd_data,
   output logic        host_rd_ack,
   output logic [2:0]  iic_start,
   output logic [7:0]  iic_addr,
   output logic [7:0]  iic_wrdata,
   input  logic [15:0] iic_rddata,
   input  logic        iic_done,
   output logic [15:0] temp_raw,
   output logic [8:0]  temp_int,
   output logic [6:0]  temp_frac,
   output logic        temp_valid,
   output logic        busy,
   output logic        timeout_err
);

   // state  | meaning
   // S_RST  | out of reset, waiting for enable
   // S_INIT | configuration write outstanding
   // S_GAP  | one idle cycle between commands
   // S_IDLE | choose next command: sample, host write, host read
   // S_TEMP | 16-bit temperature read outstanding
   // S_HWR  | host byte write outstanding
   // S_HRD  | host byte read outstanding
   typedef enum logic [2:0] {
      S_RST, S_INIT, S_GAP, S_IDLE, S_TEMP, S_HWR, S_HRD
   } state_t;

   localparam int SW = $clog2(SAMPLE_DIV + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_DIV - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

   state_t        state, state_nxt;
   logic [2:0]    start_nxt;
   logic [7:0]    addr_nxt, wrdata_nxt, rd_data_nxt;
   logic [15:0]   raw_nxt;
   logic          valid_nxt, wr_ack_nxt, rd_ack_nxt;
   logic          init_done, init_done_nxt;
   logic          issue, issue_temp;
   logic          sample_pend, sample_tick;
   logic [SW-1:0] sample_cnt;
   logic [TW-1:0] to_cnt;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state        <= S_RST;
         iic_start    <= '0;
         iic_addr     <= '0;
         iic_wrdata   <= '0;
         temp_raw     <= '0;
         temp_valid   <= 1'b0;
         host_rd_data <= '0;
         host_wr_ack  <= 1'b0;
         host_rd_ack  <= 1'b0;
         init_done    <= 1'b0;
      end else begin
         state        <= state_nxt;
         iic_start    <= start_nxt;
         iic_addr     <= addr_nxt;
         iic_wrdata   <= wrdata_nxt;
         temp_raw     <= raw_nxt;
         temp_valid   <= valid_nxt;
         host_rd_data <= rd_data_nxt;
         host_wr_ack  <= wr_ack_nxt;
         host_rd_ack  <= rd_ack_nxt;
         init_done    <= init_done_nxt;
      end
   end

   // Command fields are only loaded at issue, so they hold steady until iic_done.
   always_comb begin
      state_nxt     = state;
      start_nxt     = iic_start;
      addr_nxt      = iic_addr;
      wrdata_nxt    = iic_wrdata;
      raw_nxt       = temp_raw;
      rd_data_nxt   = host_rd_data;
      valid_nxt     = 1'b0;
      wr_ack_nxt    = 1'b0;
      rd_ack_nxt    = 1'b0;
      init_done_nxt = init_done;
      issue         = 1'b0;
      issue_temp    = 1'b0;
      case (state)
         S_RST: begin
            if (enable) begin
               state_nxt  = S_INIT;
               start_nxt  = 3'b001;
               addr_nxt   = CFG_ADDR;
               wrdata_nxt = CFG_VAL;
               issue      = 1'b1;
            end
         end
         S_INIT: begin
            if (iic_done) begin
               state_nxt     = S_GAP;
               start_nxt     = '0;
               init_done_nxt = 1'b1;
            end
         end
         S_GAP: state_nxt = S_IDLE;
         S_IDLE: begin
            if (sample_pend && enable) begin
               state_nxt  = S_TEMP;
               start_nxt  = 3'b100;
               addr_nxt   = TEMP_ADDR;
               issue      = 1'b1;
               issue_temp = 1'b1;
            end else if (host_wr_req) begin
               state_nxt  = S_HWR;
               start_nxt  = 3'b001;
               addr_nxt   = host_wr_addr;
               wrdata_nxt = host_wr_data;
               issue      = 1'b1;
            end else if (host_rd_req) begin
               state_nxt  = S_HRD;
               start_nxt  = 3'b010;
               addr_nxt   = host_rd_addr;
               issue      = 1'b1;
            end
         end
         S_TEMP: begin
            if (iic_done) begin
               state_nxt = S_GAP;
               start_nxt = '0;
               raw_nxt   = iic_rddata;
               valid_nxt = 1'b1;
            end
         end
         S_HWR: begin
            if (iic_done) begin
               state_nxt  = S_GAP;
               start_nxt  = '0;
               wr_ack_nxt = 1'b1;
            end
         end
         S_HRD: begin
            if (iic_done) begin
               state_nxt   = S_GAP;
               start_nxt   = '0;
               rd_data_nxt = iic_rddata[7:0];
               rd_ack_nxt  = 1'b1;
            end
         end
         default: state_nxt = S_RST;
      endcase
   end

   assign sample_tick = enable && init_done && (sample_cnt == SAMPLE_LAST);

   // A tick arriving while a sample is already pending is dropped, not queued.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         sample_cnt  <= '0;
         sample_pend <= 1'b0;
      end else begin
         if (enable && init_done) begin
            if (sample_cnt == SAMPLE_LAST) sample_cnt <= '0;
            else                           sample_cnt <= sample_cnt + 1'b1;
         end
         if (issue_temp)       sample_pend <= 1'b0;
         else if (sample_tick) sample_pend <= 1'b1;
      end
   end

   // The master cannot be aborted, so a timeout only flags; the command stays up.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         to_cnt      <= '0;
         timeout_err <= 1'b0;
      end else if (issue) begin
         to_cnt <= '0;
      end else if (busy) begin
         if (to_cnt == TIMEOUT_LAST) timeout_err <= 1'b1;
         else                        to_cnt      <= to_cnt + 1'b1;
      end
   end

   assign busy      = |iic_start;
   assign temp_int  = temp_raw[15:7];
   assign temp_frac = temp_raw[6:0];

endmodule

// File: tb/tb_adt7420_sched.sv
// Bench for adt7420_sched: behavioural I2C master plus a command log, checked against
// expectations derived from the sequencing, priority, timing and decoding rules.
module tb_adt7420_sched;

   localparam int SDIV = 1000;
   localparam int TOUT = 500;

   logic        CLK = 1'b0;
   logic        RSTn = 1'b0;
   logic        enable = 1'b0;
   logic        host_wr_req = 1'b0;
   logic [7:0]  host_wr_addr = '0;
   logic [7:0]  host_wr_data = '0;
   logic        host_wr_ack;
   logic        host_rd_req = 1'b0;
   logic [7:0]  host_rd_addr = '0;
   logic [7:0]  host_rd_data;
   logic        host_rd_ack;
   logic [2:0]  iic_start;
   logic [7:0]  iic_addr;
   logic [7:0]  iic_wrdata;
   logic [15:0] iic_rddata = '0;
   logic        iic_done = 1'b0;
   logic [15:0] temp_raw;
   logic [8:0]  temp_int;
   logic [6:0]  temp_frac;
   logic        temp_valid;
   logic        busy;
   logic        timeout_err;

   adt7420_sched #(.SAMPLE_DIV(SDIV), .TIMEOUT_CYC(TOUT)) dut (
      .CLK(CLK), .RSTn(RSTn), .enable(enable),
      .host_wr_req(host_wr_req), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
      .host_wr_ack(host_wr_ack),
      .host_rd_req(host_rd_req), .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data),
      .host_rd_ack(host_rd_ack),
      .iic_start(iic_start), .iic_addr(iic_addr), .iic_wrdata(iic_wrdata),
      .iic_rddata(iic_rddata), .iic_done(iic_done),
      .temp_raw(temp_raw), .temp_int(temp_int), .temp_frac(temp_frac), .temp_valid(temp_valid),
      .busy(busy), .timeout_err(timeout_err)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc++;

   typedef struct {
      logic [2:0] start;
      logic [7:0] addr;
      logic [7:0] data;
      int         cyc;
   } cmd_t;

   cmd_t        cmd_q[$];
   cmd_t        cur;
   int          vectors = 0;
   int          miscompares = 0;
   int          proto_err = 0;
   int          dly = 50;
   int          mcnt = 0;
   int          done_cyc = 0;
   logic [15:0] temp_val = 16'h0D80;
   logic [7:0]  rd8 = 8'h00;

   // I2C master model: logs each command, checks it stays stable and one-hot,
   // and pulses iic_done dly cycles after the command appears.
   always @(negedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         iic_done = 1'b0;
         mcnt     = 0;
      end else begin
         iic_done = 1'b0;
         if (busy !== (iic_start != 3'b000)) proto_err++;
         if (iic_start == 3'b000) begin
            mcnt = 0;
         end else begin
            if (!$onehot(iic_start)) proto_err++;
            mcnt++;
            if (mcnt == 1) begin
               cur.start = iic_start;
               cur.addr  = iic_addr;
               cur.data  = iic_wrdata;
               cur.cyc   = cyc;
               cmd_q.push_back(cur);
            end else if ({iic_start, iic_addr, iic_wrdata} !== {cur.start, cur.addr, cur.data}) begin
               proto_err++;
            end
            if (mcnt == dly) begin
               iic_done = 1'b1;
               done_cyc = cyc;
               if (iic_start[2]) iic_rddata = temp_val;
               else              iic_rddata = {8'($urandom_range(0, 255)), rd8};
            end
         end
      end
   end

   task automatic tick();
      @(negedge CLK);
      #1;
   endtask

   task automatic wait_cmd(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (cmd_q.size() > n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic host_run(input bit do_wr, input bit do_rd, input int budget,
                           output int wa, output int ra);
      wa = 0;
      ra = 0;
      host_wr_req = do_wr;
      host_rd_req = do_rd;
      for (int i = 0; i < budget && (host_wr_req || host_rd_req); i++) begin
         tick();
         if (host_wr_ack) begin wa++; host_wr_req = 1'b0; end
         if (host_rd_ack) begin ra++; host_rd_req = 1'b0; end
      end
      host_wr_req = 1'b0;
      host_rd_req = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (host_wr_ack) wa++;
         if (host_rd_ack) ra++;
      end
   endtask

   function automatic logic [77:0] all_outs();
      return {host_wr_ack, host_rd_ack, host_rd_data, iic_start, iic_addr, iic_wrdata,
              temp_raw, temp_int, temp_frac, temp_valid, busy, timeout_err};
   endfunction

   task automatic test_reset();
      RSTn = 1'b0;
      enable = 1'b0;
      repeat (5) tick();
      vectors++;
      if (all_outs() !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h, required 0", all_outs());
      end
      RSTn = 1'b1;
      repeat (20) tick();
      vectors++;
      if (cmd_q.size() != 0) begin
         miscompares++;
         $display("FAIL idle_without_enable: %0d commands issued, required 0", cmd_q.size());
      end
   endtask

   task automatic test_init();
      bit ok;
      int n;
      int d;
      enable = 1'b1;
      n = cmd_q.size();
      wait_cmd(n, 20, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL init_issue: no command within 20 cycles, required config write");
         return;
      end
      vectors++;
      if ({cmd_q[n].start, cmd_q[n].addr, cmd_q[n].data} !== {3'b001, 8'h03, 8'h80}) begin
         miscompares++;
         $display("FAIL init_cmd: got %b/%h/%h, required 001/03/80",
                  cmd_q[n].start, cmd_q[n].addr, cmd_q[n].data);
      end
      ok = 1'b0;
      d = 0;
      for (int i = 0; i < 100; i++) begin
         if (iic_done) begin ok = 1'b1; d = done_cyc; break; end
         tick();
      end
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL init_done: command never completed, required done after 50 cycles");
         return;
      end
      tick();
      vectors++;
      if (busy !== 1'b0 || iic_start !== 3'b000 || cyc != d + 1) begin
         miscompares++;
         $display("FAIL init_release: busy=%b start=%b at cycle %0d, required 0/000 at %0d",
                  busy, iic_start, cyc, d + 1);
      end
      tick();
      vectors++;
      if (cmd_q.size() != n + 1) begin
         miscompares++;
         $display("FAIL init_gap: %0d commands by done+2, required %0d", cmd_q.size(), n + 1);
      end
   endtask

   task automatic test_sampling();
      logic [15:0] vals[5];
      logic [15:0] v;
      logic [8:0]  ei;
      logic [6:0]  ef;
      int          n, prev, t, fr, ip;
      bit          ok;
      vals[0] = 16'h0D80;
      vals[1] = 16'hF380;
      for (int k = 2; k < 5; k++) vals[k] = 16'($urandom_range(0, 65535));
      prev = 0;
      for (int i = 0; i < 5; i++) begin
         v = vals[i];
         temp_val = v;
         t  = v[15] ? int'(v) - 65536 : int'(v);
         fr = int'(v) % 128;
         ip = (t - fr) / 128;
         ei = ip[8:0];
         ef = fr[6:0];
         n = cmd_q.size();
         wait_cmd(n, SDIV + 200, ok);
         vectors++;
         if (!ok) begin
            miscompares++;
            $display("FAIL sample_issue[%0d]: no temperature read, required one per %0d cycles", i, SDIV);
            return;
         end
         vectors++;
         if ({cmd_q[n].start, cmd_q[n].addr} !== {3'b100, 8'h00}) begin
            miscompares++;
            $display("FAIL sample_cmd[%0d]: got %b/%h, required 100/00", i, cmd_q[n].start, cmd_q[n].addr);
         end
         if (i > 0) begin
            vectors++;
            if (cmd_q[n].cyc - prev != SDIV) begin
               miscompares++;
               $display("FAIL sample_period[%0d]: got %0d cycles, required %0d", i, cmd_q[n].cyc - prev, SDIV);
            end
         end
         prev = cmd_q[n].cyc;
         ok = 1'b0;
         for (int j = 0; j < 100; j++) begin
            tick();
            if (temp_valid) begin ok = 1'b1; break; end
         end
         vectors++;
         if (!ok || cyc != done_cyc + 1) begin
            miscompares++;
            $display("FAIL temp_valid_time[%0d]: seen=%0b at cycle %0d, required at %0d", i, ok, cyc, done_cyc + 1);
         end
         vectors++;
         if ({temp_raw, temp_int, temp_frac} !== {v, ei, ef}) begin
            miscompares++;
            $display("FAIL temp_decode[%0d]: got raw=%h int=%h frac=%h, required %h/%h/%h",
                     i, temp_raw, temp_int, temp_frac, v, ei, ef);
         end
         tick();
         vectors++;
         if (temp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL temp_valid_width[%0d]: got %b one cycle later, required 0", i, temp_valid);
         end
      end
   endtask

   task automatic test_arbitration();
      int c, n, wa, ra;
      c = cmd_q[cmd_q.size() - 1].cyc;
      for (int i = 0; i < SDIV + 100 && cyc < c + SDIV - 1; i++) tick();
      host_wr_addr = 8'h08;
      host_wr_data = 8'h55;
      host_rd_addr = 8'h0B;
      rd8 = 8'hCB;
      n = cmd_q.size();
      host_run(1'b1, 1'b1, 1500, wa, ra);
      vectors++;
      if (wa != 1 || ra != 1) begin
         miscompares++;
         $display("FAIL arb_acks: got wr=%0d rd=%0d, required 1/1", wa, ra);
      end
      vectors++;
      if (cmd_q.size() != n + 3) begin
         miscompares++;
         $display("FAIL arb_count: got %0d commands, required 3", cmd_q.size() - n);
         return;
      end
      vectors++;
      if ({cmd_q[n].start, cmd_q[n].addr, cmd_q[n+1].start, cmd_q[n+1].addr, cmd_q[n+1].data,
           cmd_q[n+2].start, cmd_q[n+2].addr} !== {3'b100, 8'h00, 3'b001, 8'h08, 8'h55, 3'b010, 8'h0B}) begin
         miscompares++;
         $display("FAIL arb_order: got %b/%h %b/%h/%h %b/%h, required 100/00 001/08/55 010/0B",
                  cmd_q[n].start, cmd_q[n].addr, cmd_q[n+1].start, cmd_q[n+1].addr, cmd_q[n+1].data,
                  cmd_q[n+2].start, cmd_q[n+2].addr);
      end
      vectors++;
      if (cmd_q[n].cyc != c + SDIV) begin
         miscompares++;
         $display("FAIL arb_tick: temp read at %0d, required %0d", cmd_q[n].cyc, c + SDIV);
      end
      vectors++;
      if (host_rd_data !== 8'hCB) begin
         miscompares++;
         $display("FAIL arb_rd_data: got %h, required CB", host_rd_data);
      end
   endtask

   task automatic test_host_random();
      int wa, ra;
      cmd_t w, r;
      for (int i = 0; i < 3; i++) begin
         host_wr_addr = 8'($urandom_range(0, 255));
         host_wr_data = 8'($urandom_range(0, 255));
         host_run(1'b1, 1'b0, 1500, wa, ra);
         w = cmd_q[cmd_q.size() - 1];
         for (int k = cmd_q.size() - 1; k >= 0; k--)
            if (cmd_q[k].start == 3'b001) begin w = cmd_q[k]; break; end
         vectors++;
         if (wa != 1 || {w.start, w.addr, w.data} !== {3'b001, host_wr_addr, host_wr_data}) begin
            miscompares++;
            $display("FAIL host_wr[%0d]: acks=%0d cmd=%b/%h/%h, required 1 001/%h/%h",
                     i, wa, w.start, w.addr, w.data, host_wr_addr, host_wr_data);
         end
         host_rd_addr = 8'($urandom_range(0, 255));
         rd8 = 8'($urandom_range(0, 255));
         host_run(1'b0, 1'b1, 1500, wa, ra);
         r = cmd_q[cmd_q.size() - 1];
         for (int k = cmd_q.size() - 1; k >= 0; k--)
            if (cmd_q[k].start == 3'b010) begin r = cmd_q[k]; break; end
         vectors++;
         if (ra != 1 || r.addr !== host_rd_addr || host_rd_data !== rd8) begin
            miscompares++;
            $display("FAIL host_rd[%0d]: acks=%0d addr=%h data=%h, required 1 %h %h",
                     i, ra, r.addr, host_rd_data, host_rd_addr, rd8);
         end
      end
   endtask

   task automatic test_timeout();
      int n, n2, ci, wa, temps;
      bit ok;
      enable = 1'b0;
      repeat (60) tick();
      dly = 600;
      host_wr_addr = 8'($urandom_range(0, 255));
      host_wr_data = 8'($urandom_range(0, 255));
      n = cmd_q.size();
      host_wr_req = 1'b1;
      wait_cmd(n, 20, ok);
      vectors++;
      if (!ok || cmd_q[n].start !== 3'b001) begin
         miscompares++;
         $display("FAIL to_issue: no host write issued with enable low, required one");
         host_wr_req = 1'b0;
         dly = 50;
         return;
      end
      ci = cmd_q[n].cyc;
      while (cyc < ci + TOUT - 1) tick();
      vectors++;
      if (timeout_err !== 1'b0) begin
         miscompares++;
         $display("FAIL to_early: got %b at issue+%0d, required 0", timeout_err, TOUT - 1);
      end
      tick();
      vectors++;
      if (timeout_err !== 1'b1) begin
         miscompares++;
         $display("FAIL to_set: got %b at issue+%0d, required 1", timeout_err, TOUT);
      end
      while (cyc < ci + 550) tick();
      vectors++;
      if ({iic_start, iic_addr, iic_wrdata} !== {3'b001, host_wr_addr, host_wr_data}) begin
         miscompares++;
         $display("FAIL to_hold: got %b/%h/%h, required 001/%h/%h",
                  iic_start, iic_addr, iic_wrdata, host_wr_addr, host_wr_data);
      end
      wa = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (host_wr_ack) begin wa++; host_wr_req = 1'b0; break; end
      end
      host_wr_req = 1'b0;
      dly = 50;
      vectors++;
      if (wa != 1 || timeout_err !== 1'b1) begin
         miscompares++;
         $display("FAIL to_complete: acks=%0d err=%b, required 1 and 1", wa, timeout_err);
      end
      n2 = cmd_q.size();
      repeat (SDIV + 200) tick();
      temps = 0;
      for (int k = n2; k < cmd_q.size(); k++) if (cmd_q[k].start == 3'b100) temps++;
      vectors++;
      if (temps != 0) begin
         miscompares++;
         $display("FAIL disabled_sampling: got %0d temperature reads, required 0", temps);
      end
      enable = 1'b1;
      n2 = cmd_q.size();
      wait_cmd(n2, SDIV + 100, ok);
      vectors++;
      if (!ok || cmd_q[n2].start !== 3'b100 || timeout_err !== 1'b1) begin
         miscompares++;
         $display("FAIL resume_sampling: issued=%0b err=%b, required temperature read and err 1", ok, timeout_err);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      bit ok;
      repeat (10) tick();
      vectors++;
      if (iic_start !== 3'b100) begin
         miscompares++;
         $display("FAIL mid_precond: start=%b, required 100", iic_start);
      end
      #1 RSTn = 1'b0;
      #1;
      vectors++;
      if (all_outs() !== '0) begin
         miscompares++;
         $display("FAIL mid_reset_outputs: got %h, required 0", all_outs());
      end
      repeat (3) tick();
      RSTn = 1'b1;
      n = cmd_q.size();
      wait_cmd(n, 20, ok);
      vectors++;
      if (!ok || {cmd_q[n].start, cmd_q[n].addr, cmd_q[n].data} !== {3'b001, 8'h03, 8'h80}) begin
         miscompares++;
         $display("FAIL reinit: issued=%0b, required 001/03/80 after reset", ok);
      end
      repeat (60) tick();
   endtask

   task automatic test_protocol();
      vectors++;
      if (proto_err != 0) begin
         miscompares++;
         $display("FAIL protocol: got %0d stability/one-hot/busy violations, required 0", proto_err);
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_sampling();
      test_arbitration();
      test_host_random();
      test_timeout();
      test_reset_mid();
      test_protocol();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
